// File: rtl/iir_coeff_loader_pkg.sv
// Shared types and constants for the SPI biquad coefficient loader.
// A frame is five Q2.14 words, b0 first, shifted in MSB first.
package iir_coeff_pkg;

    localparam int COEFF_W    = 16;
    localparam int NUM_COEFFS = 5;
    localparam int FRAME_BITS = 80;

    typedef logic signed [15:0] coeff_t;

    localparam coeff_t COEFF_ONE = 16'sd16384;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } loader_state_e;

endpackage

// File: rtl/iir_coeff_loader_if.sv
// SPI pins, sample strobe and the coefficient/status outputs of the loader.
// The loader drives the slave side; the MCU/filter environment the master side.
interface iir_coeff_loader_if;
    import iir_coeff_pkg::*;

    logic   sck;
    logic   sdi;
    logic   cs_n;
    logic   sample_strobe;
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
    logic   load_pending;
    logic   coeff_update;
    logic   frame_err;

    modport master (
        output sck, sdi, cs_n, sample_strobe,
        input  b0, b1, b2, a1, a2, load_pending, coeff_update, frame_err
    );

    modport slave (
        input  sck, sdi, cs_n, sample_strobe,
        output b0, b1, b2, a1, a2, load_pending, coeff_update, frame_err
    );

endinterface

// File: rtl/iir_coeff_loader_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses, aligned with the
// cycle in which the synchronized level itself changes.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;
    logic              fall_q;

    // Synchronizer chain; edges come from the last two stages so they line up with level_o
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/iir_coeff_loader.sv
// SPI receiver for one biquad coefficient set, double-buffered and committed
// to the filter outputs only on a sample strobe.
module iir_coeff_loader #(
    parameter int COEFF_W     = iir_coeff_pkg::COEFF_W,
    parameter int NUM_COEFFS  = iir_coeff_pkg::NUM_COEFFS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    iir_coeff_loader_if.slave   bus
);
    import iir_coeff_pkg::*;

    localparam int FRAME_W = COEFF_W * NUM_COEFFS;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(FRAME_W + 1);
    localparam logic [FRAME_W-1:0] ACTIVE_RST = FRAME_W'(COEFF_ONE) << (FRAME_W - COEFF_W);

    logic sck_rise_s, sck_lvl_unused_s, sck_fall_unused_s;
    logic cs_rise_s, cs_fall_s, cs_lvl_unused_s;
    logic sdi_s;
    logic commit_s;

    logic [SYNC_STAGES-1:0] sdi_sync_q;
    loader_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [FRAME_W-1:0]     stage_q, stage_d;
    logic [FRAME_W-1:0]     active_q, active_d;
    logic                   pending_q, pending_d;
    logic                   update_q, update_d;
    logic                   err_q, err_d;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.sck),
        .level_o (sck_lvl_unused_s),
        .rise_o  (sck_rise_s),
        .fall_o  (sck_fall_unused_s)
    );

    // cs_n resets low so a chip select already asserted at release is not seen as a new frame
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.cs_n),
        .level_o (cs_lvl_unused_s),
        .rise_o  (cs_rise_s),
        .fall_o  (cs_fall_s)
    );

    // Data line synchronizer, same depth as sck so the sample matches the detected rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
        end
    end

    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign commit_s = bus.sample_strobe & pending_q;

    // State, frame buffers and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            shift_q   <= {FRAME_W{1'b0}};
            stage_q   <= {FRAME_W{1'b0}};
            active_q  <= ACTIVE_RST;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            stage_q   <= stage_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end

    // Commit sees the old staged set, so a frame ending on the strobe edge stays pending
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        stage_d   = stage_q;
        active_d  = active_q;
        pending_d = pending_q;
        update_d  = 1'b0;
        err_d     = 1'b0;

        if (commit_s) begin
            active_d  = stage_q;
            pending_d = 1'b0;
            update_d  = 1'b1;
        end else begin
            active_d  = active_q;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {FRAME_W{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sck_rise_s) begin
                    shift_d = {shift_q[FRAME_W-2:0], sdi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    shift_d = shift_q;
                end
                if (cs_rise_s) begin
                    state_d = CHECK;
                end else begin
                    state_d = SHIFT;
                end
            end
            CHECK: begin
                if (cnt_q == CNT_FULL) begin
                    stage_d   = shift_q;
                    pending_d = 1'b1;
                end else begin
                    err_d     = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.b0           = coeff_t'(active_q[FRAME_W-1             -: COEFF_W]);
    assign bus.b1           = coeff_t'(active_q[FRAME_W-1-COEFF_W     -: COEFF_W]);
    assign bus.b2           = coeff_t'(active_q[FRAME_W-1-2*COEFF_W   -: COEFF_W]);
    assign bus.a1           = coeff_t'(active_q[FRAME_W-1-3*COEFF_W   -: COEFF_W]);
    assign bus.a2           = coeff_t'(active_q[FRAME_W-1-4*COEFF_W   -: COEFF_W]);
    assign bus.load_pending = pending_q;
    assign bus.coeff_update = update_q;
    assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed plus randomized bench for iir_coeff_loader, checked against a
// word-level model of the active set, staged set and pending flag.
module tb_iir_coeff_loader;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    iir_coeff_loader_if bus ();

    iir_coeff_loader #(
        .COEFF_W     (16),
        .NUM_COEFFS  (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int upd_pulses = 0;

    logic [15:0] m_act [5];
    logic [15:0] m_stg [5];
    bit          m_pend;

    always @(posedge clk) begin
        if (bus.frame_err === 1'b1) err_pulses <= err_pulses + 1;
        if (bus.coeff_update === 1'b1) upd_pulses <= upd_pulses + 1;
    end

    function automatic logic [79:0] pack_set(input logic [15:0] w [5]);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [79:0] dut_set();
        return {bus.b0, bus.b1, bus.b2, bus.a1, bus.a2};
    endfunction

    task automatic check_set(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        m_pend = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] w [5], input int nbits);
        if (nbits == 80) begin
            m_stg  = w;
            m_pend = 1'b1;
        end
    endtask

    task automatic model_strobe();
        if (m_pend) begin
            m_act  = m_stg;
            m_pend = 1'b0;
        end
    endtask

    task automatic rand_set(output logic [15:0] w [5]);
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
    endtask

    // Mode 0: data set while sck is low, sck high/low for 4 clk each (8x ratio)
    task automatic spi_bits(input logic [15:0] w [5], input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            if (k < 80) bus.sdi = w[k / 16][15 - (k % 16)];
            else        bus.sdi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            bus.sck = 1'b1;
            repeat (4) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] w [5], input int nbits);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(w, 0, nbits);
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
    endtask

    task automatic strobe();
        bus.sample_strobe = 1'b1;
        @(negedge clk);
        bus.sample_strobe = 1'b0;
        model_strobe();
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] wa [5];
        logic [15:0] wb [5];
        int e0;
        int u0;
        int nb;

        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.cs_n = 1'b1;
        bus.sample_strobe = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_set("reset_coeffs", dut_set(), 80'h4000_0000_0000_0000_0000);
        check_bit("reset_pending", bus.load_pending, 1'b0);
        check_bit("reset_update", bus.coeff_update, 1'b0);
        check_bit("reset_err", bus.frame_err, 1'b0);
        reset_n = 1'b1;
        settle();
        check_int("release_no_err", err_pulses, 0);

        // Bad lengths: 79, 81 and zero clocks
        e0 = err_pulses;
        rand_set(wa);
        spi_frame(wa, 79); settle();
        spi_frame(wa, 81); settle();
        check_int("bad_len_err2", err_pulses - e0, 2);
        spi_frame(wa, 0); settle();
        check_int("bad_len_err3", err_pulses - e0, 3);
        check_bit("bad_len_pending", bus.load_pending, 1'b0);
        check_set("bad_len_coeffs", dut_set(), pack_set(m_act));

        // Valid frame, including cs_n-rise to load_pending latency
        wa = '{16'h2000, 16'h1000, 16'h0800, 16'hC000, 16'h1F00};
        spi_frame(wa, 80);
        model_frame(wa, 80);
        repeat (3) @(negedge clk);
        check_bit("latency_early", bus.load_pending, 1'b0);
        @(negedge clk);
        check_bit("latency_pending", bus.load_pending, 1'b1);
        settle();
        check_set("valid_unchanged", dut_set(), 80'h4000_0000_0000_0000_0000);
        u0 = upd_pulses;
        strobe();
        check_set("valid_commit", dut_set(), 80'h2000_1000_0800_C000_1F00);
        check_bit("valid_update_hi", bus.coeff_update, 1'b1);
        check_bit("valid_pending_lo", bus.load_pending, 1'b0);
        @(negedge clk);
        check_bit("valid_update_lo", bus.coeff_update, 1'b0);
        settle();
        check_int("valid_update_once", upd_pulses - u0, 1);

        // Last frame wins
        e0 = err_pulses;
        rand_set(wa); rand_set(wb);
        spi_frame(wa, 80); model_frame(wa, 80); settle();
        spi_frame(wb, 80); model_frame(wb, 80); settle();
        u0 = upd_pulses;
        strobe();
        check_set("last_wins", dut_set(), pack_set(wb));
        settle();
        check_int("last_wins_update", upd_pulses - u0, 1);
        check_int("last_wins_no_err", err_pulses - e0, 0);

        // Frame end of B lands on the strobe edge while A is pending
        rand_set(wa); rand_set(wb);
        spi_frame(wa, 80); model_frame(wa, 80); settle();
        spi_frame(wb, 80);
        repeat (3) @(negedge clk);
        strobe();
        model_frame(wb, 80);
        settle();
        check_set("simul_old_commit", dut_set(), pack_set(m_act));
        check_set("simul_is_a", dut_set(), pack_set(wa));
        check_bit("simul_pending", bus.load_pending, 1'b1);
        strobe();
        check_set("simul_next_b", dut_set(), pack_set(wb));
        check_bit("simul_pending_lo", bus.load_pending, 1'b0);

        // Randomized frames of random length with optional strobes
        for (int it = 0; it < 6; it++) begin
            rand_set(wa);
            nb = ($urandom_range(0, 3) == 0) ? 79 + 2 * $urandom_range(0, 1) : 80;
            spi_frame(wa, nb);
            model_frame(wa, nb);
            settle();
            if ($urandom_range(0, 1) == 1) strobe();
            else @(negedge clk);
            check_set("rand_coeffs", dut_set(), pack_set(m_act));
            check_bit("rand_pending", bus.load_pending, m_pend);
        end

        // Reset in the middle of a frame with a set pending
        rand_set(wa);
        spi_frame(wa, 80); model_frame(wa, 80); settle();
        rand_set(wb);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(wb, 0, 40);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_set("midrst_coeffs", dut_set(), 80'h4000_0000_0000_0000_0000);
        check_bit("midrst_pending", bus.load_pending, 1'b0);
        reset_n = 1'b1;
        e0 = err_pulses;
        spi_bits(wb, 40, 80);
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        settle();
        check_bit("midrst_tail_pending", bus.load_pending, 1'b0);
        check_set("midrst_tail_coeffs", dut_set(), pack_set(m_act));
        rand_set(wa);
        spi_frame(wa, 80); model_frame(wa, 80); settle();
        strobe();
        check_set("midrst_frame_c", dut_set(), pack_set(wa));
        settle();
        check_int("midrst_no_err", err_pulses - e0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Receives biquad coefficients from the MCU over SPI and presents them to the IIR filter as registered Q2.14 words. Sits directly upstream of the filter's `b0`/`b1`/`b2`/`a1`/`a2` inputs. A complete 80-bit frame is double-buffered in the FPGA clock domain. The buffered set is applied atomically on a sample boundary, so the filter never runs with a mix of old and new coefficients.

## Interface

Parameters:
- `COEFF_W`, default 16: coefficient width, in Q2.14.
- `NUM_COEFFS`, default 5: words per frame, in the order b0, b1, b2, a1, a2.
- `SYNC_STAGES`, default 2: flip-flop stages on each asynchronous SPI input.

Ports:
- `clk`, input, 1: system clock. Must run at ≥ 8× the `sck` frequency.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `sck`, input, 1: SPI clock from the MCU, asynchronous, mode 0.
- `sdi`, input, 1: SPI data, MSB first.
- `cs_n`, input, 1: SPI chip select, active low. Frames one coefficient set.
- `sample_strobe`, input, 1: one-cycle pulse per audio sample, in the `clk` domain.
- `b0`, `b1`, `b2`, `a1`, `a2`, output, signed 16 each: active coefficients.
- `load_pending`, output, 1: a valid set is staged and waiting for a strobe.
- `coeff_update`, output, 1: one-cycle pulse in the cycle after the active set changes.
- `frame_err`, output, 1: one-cycle pulse when a frame is discarded.

## Operation

- `sck`, `sdi` and `cs_n` each pass through a `SYNC_STAGES` synchronizer followed by an edge detector.
- `sdi` is sampled on the synchronized rising edge of `sck`.
- State machine:
  - IDLE: a `cs_n` falling edge clears the bit counter and the shift register, then goes to SHIFT.
  - SHIFT: each `sck` rise shifts the synced `sdi` into an 80-bit shift register and increments the bit counter.
    - The counter saturates at 81.
    - A `cs_n` rising edge goes to CHECK.
  - CHECK, one cycle:
    - If the count is exactly 80, copy the shift register into the staging register and set `load_pending`.
    - Otherwise pulse `frame_err` and leave the staging register untouched.
    - Always return to IDLE.
- Word mapping: bits [79:64] are b0, [63:48] b1, [47:32] b2, [31:16] a1, [15:0] a2.
  - a1 and a2 are stored exactly as sent. The sign convention is that of the filter.
  - No saturation or range checking is applied.
- Commit: on a clk edge where `sample_strobe` = 1 and `load_pending` = 1:
  - the staging register is copied to the outputs;
  - `load_pending` clears;
  - `coeff_update` pulses in the next cycle.
- Reset values: b0 = 16384 (unity, 0x4000); b1, b2, a1 and a2 = 0; `load_pending`, `coeff_update` and `frame_err` = 0; state = IDLE. The filter therefore passes audio through after reset.

## Timing

- Latency from `cs_n` rise at the pin to `load_pending` = 1 is `SYNC_STAGES` + 2 clk cycles.
- Latency from strobe to new outputs is 1 edge, the strobe edge itself. Outputs are registered and change only on commit.
- Boundary conditions:
  - Frame-end and strobe in the same cycle with nothing pending: the new set is staged and commits on the next strobe.
  - Frame-end and strobe in the same cycle with a set already pending: the old staged set commits, the new set is staged, and `load_pending` stays 1.
  - A second valid frame before any strobe: the last frame wins and the earlier staged set is overwritten. No error is raised.
  - More than 80 `sck` rises, fewer than 80, or zero: `frame_err`, and the set is discarded.
  - `cs_n` rises while the block is in IDLE: ignored.
  - `reset_n` low mid-frame or with a set pending: the partial frame and the staged set are lost and the outputs return to the reset values.
  - Pins after reset release: the block waits for a fresh `cs_n` falling edge. A `cs_n` that is already low at release is ignored until the next falling edge.

## Structure

- Package `iir_coeff_pkg` holds:
  - `COEFF_W`, `NUM_COEFFS` and `FRAME_BITS` = 80;
  - `COEFF_ONE` = 16'sd16384;
  - the typedef `coeff_t` (signed [15:0]);
  - the loader state enum (IDLE, SHIFT, CHECK).
- Sub-module `sync_edge`: an N-stage synchronizer with registered rise and fall outputs. It is instantiated for `sck` and `cs_n`; the `sdi` path uses the synchronizer stages only.
- The top level contains the FSM, the bit counter, the shift register, the staging register and the output registers.

## Test plan

- **Reset:** assert `reset_n` = 0 with pins idle → b0 = 16384, all other coefficients 0, all flags 0.
- **Valid frame:** send 80 bits encoding 0x2000, 0x1000, 0x0800, 0xC000, 0x1F00 with no strobe → outputs unchanged and `load_pending` = 1. Pulse `sample_strobe` → outputs take exactly those values on that edge, `coeff_update` pulses once in the next cycle, and `load_pending` = 0.
- **Bad length:** send a 79-bit frame, then an 81-bit frame → `frame_err` pulses twice, `load_pending` stays 0, and the outputs keep the reset values.
- **Last wins:** send set A, then set B, with no strobe in between, then one strobe → the outputs equal B and `coeff_update` pulses once.
- **Simultaneous events:** with A pending, align B's frame-end with a strobe → the outputs become A and `load_pending` stays 1. The next strobe → the outputs become B.
- **Reset mid-operation:** pull `reset_n` low after 40 bits of a frame, release it, then send a full valid frame C plus a strobe → the outputs equal C with no `frame_err` pulse.
